// File: rtl/jts16_snd_pkg.sv
// Shared types and constants for the main-to-sound command channel (jts16_snd_cmd).
package jts16_snd_pkg;

    localparam int             CMD_W       = 8;
    localparam int             NMI_LEN_DEF = 16;
    localparam logic [CMD_W-1:0] DATA_RST  = 8'hff;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NMI     = 2'd1,
        WAIT_RD = 2'd2
    } snd_state_e;

endpackage

// File: rtl/jts16_snd_fifo.sv
// Small synchronous command queue; head is the oldest entry, valid whenever empty is low.
module jts16_snd_fifo
    import jts16_snd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [W-1:0]             head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (level_r == (AW+1)'(DEPTH));
    assign empty     = (level_r == {(AW+1){1'b0}});
    assign level     = level_r;
    assign head      = mem_r[rd_ptr_r];
    // A push into a full queue is only legal when the head leaves in the same cycle
    assign do_push_s = push & (~full | pop);
    assign do_pop_s  = pop & ~empty;

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_RST;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
        end
    end

endmodule

// File: rtl/jts16_snd_cmd.sv
// Sound-CPU end of the main-to-sound command channel: captures PPI commands, raises NMI, serves Z80 reads.
// Define JTS16_SNDCMD_FIFO_EN to queue commands in a FIFO_DEPTH-entry FIFO instead of a single latch.
module jts16_snd_cmd
    import jts16_snd_pkg::*;
#(
    parameter int NMI_LEN    = NMI_LEN_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [CMD_W-1:0] snd_latch,
    input  logic             snd_irqn,
    output logic             snd_ack,
    input  logic             latch_cs,
    input  logic             rd_n,
    output logic             nmi_n,
    output logic [CMD_W-1:0] dout,
    output logic             pending,
    output logic             ovf
);

    localparam logic [7:0] NMI_LOAD = 8'(NMI_LEN);

    snd_state_e       state_r;
    snd_state_e       state_nx;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_nx;
    logic             nmi_nx;
    logic             irqn_last_r;
    logic             rd_last_r;
    logic             rd_edge_r;
    logic             fall_s;
    logic             rd_ok_s;
    logic             rd_s;
    logic             pop_s;
    logic             more_s;
    logic             trig_s;
    logic             ovf_set_s;
    logic             pend_nx_s;
    logic             rd_load_s;
    logic [CMD_W-1:0] head_s;

    assign fall_s  = irqn_last_r & ~snd_irqn;
    assign rd_ok_s = latch_cs & ~rd_n;
    assign rd_s    = rd_edge_r;

    // Strobe history every clk; read history only on Z80 clock enables, one pulse per read
    always_ff @(posedge clk) begin
        if (rst) begin
            irqn_last_r <= 1'b1;
            rd_last_r   <= 1'b0;
            rd_edge_r   <= 1'b0;
        end else begin
            irqn_last_r <= snd_irqn;
            if (cen) begin
                rd_last_r <= rd_ok_s;
                rd_edge_r <= rd_ok_s & ~rd_last_r;
            end else begin
                rd_edge_r <= 1'b0;
            end
        end
    end

`ifdef JTS16_SNDCMD_FIFO_EN
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic [LW-1:0] level_s;
    logic [LW-1:0] level_nx_s;

    // A full queue still accepts a push when the head is popped in the same clk
    assign pop_s      = rd_s & ~empty_s;
    assign push_ok_s  = fall_s & (~full_s | pop_s);
    assign level_nx_s = level_s + LW'(push_ok_s) - LW'(pop_s);
    assign more_s     = (level_nx_s != {LW{1'b0}});
    assign trig_s     = push_ok_s & (state_r != NMI);
    assign ovf_set_s  = fall_s & ~push_ok_s;
    assign pend_nx_s  = more_s;
    assign rd_load_s  = pop_s;

    jts16_snd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok_s),
        .pop   (pop_s),
        .din   (snd_latch),
        .full  (full_s),
        .empty (empty_s),
        .level (level_s),
        .head  (head_s)
    );
`else
    logic [CMD_W-1:0] data_r;

    // A read coinciding with a new strobe consumes the old byte, so it never counts as an overrun
    assign head_s    = data_r;
    assign pop_s     = rd_s & pending;
    assign more_s    = fall_s;
    assign trig_s    = fall_s;
    assign ovf_set_s = fall_s & pending & ~rd_s;
    assign pend_nx_s = fall_s | (pending & ~pop_s);
    assign rd_load_s = rd_s;

    // Single command latch
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= DATA_RST;
        end else if (fall_s) begin
            data_r <= snd_latch;
        end else begin
            data_r <= data_r;
        end
    end
`endif

    // Next-state logic: consumption first, then a new NMI request, then the NMI countdown
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        nmi_nx   = nmi_n;
        if (pop_s && more_s) begin
            state_nx = NMI;
            cnt_nx   = NMI_LOAD;
            nmi_nx   = 1'b0;
        end else if (pop_s) begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
            nmi_nx   = 1'b1;
        end else if (trig_s) begin
            state_nx = NMI;
            cnt_nx   = NMI_LOAD;
            nmi_nx   = 1'b0;
        end else begin
            case (state_r)
                NMI: begin
                    if (!cen) begin
                        cnt_nx = cnt_r;
                    end else if (cnt_r <= 8'd1) begin
                        state_nx = WAIT_RD;
                        cnt_nx   = 8'd0;
                        nmi_nx   = 1'b1;
                    end else begin
                        cnt_nx = cnt_r - 8'd1;
                    end
                end
                IDLE:    state_nx = IDLE;
                WAIT_RD: state_nx = WAIT_RD;
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                    nmi_nx   = 1'b1;
                end
            endcase
        end
    end

    // Registered FSM state and all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            nmi_n   <= 1'b1;
            snd_ack <= 1'b1;
            pending <= 1'b0;
            ovf     <= 1'b0;
            dout    <= DATA_RST;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            nmi_n   <= nmi_nx;
            pending <= pend_nx_s;
            snd_ack <= ~pend_nx_s;
            ovf     <= ovf | ovf_set_s;
            if (rd_load_s) begin
                dout <= head_s;
            end else begin
                dout <= dout;
            end
        end
    end

endmodule

// File: tb/tb_jts16_snd_cmd.sv
// Self-checking bench for jts16_snd_cmd; the FIFO scenarios build when JTS16_SNDCMD_FIFO_EN is defined.
module tb_jts16_snd_cmd;

    localparam int NMI_LEN    = 16;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, cen, snd_irqn, latch_cs, rd_n;
    logic       snd_ack, nmi_n, pending, ovf;
    logic [7:0] snd_latch, dout;

    int errors = 0;
    int checks = 0;

    // reference model: commands not yet read, last byte returned, sticky overrun
    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf;

    jts16_snd_cmd #(.NMI_LEN(NMI_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .cen(cen), .snd_latch(snd_latch), .snd_irqn(snd_irqn),
        .snd_ack(snd_ack), .latch_cs(latch_cs), .rd_n(rd_n), .nmi_n(nmi_n),
        .dout(dout), .pending(pending), .ovf(ovf)
    );

    initial forever #5 clk = ~clk;

    // cen is high on every other rising edge; at a falling edge it shows the value for the next rise
    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #1 cen = ~cen;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; snd_irqn = 1'b1; latch_cs = 1'b0; rd_n = 1'b1; snd_latch = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        q.delete(); exp_dout = 8'hff; exp_ovf = 1'b0;
    endtask

    task automatic fire_cmd(input logic [7:0] b);
        snd_latch = b; snd_irqn = 1'b0;
        tick();
        snd_irqn = 1'b1;
    endtask

    // assert a read just before an enabled edge; returns one clk after the edge is seen
    task automatic do_read();
        for (int g = 0; g < 8 && cen !== 1'b1; g++) tick();
        latch_cs = 1'b1; rd_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic end_read();
        latch_cs = 1'b0; rd_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic read_and_fall(input logic [7:0] b);
        for (int g = 0; g < 8 && cen !== 1'b1; g++) tick();
        latch_cs = 1'b1; rd_n = 1'b0;
        tick();
        snd_latch = b; snd_irqn = 1'b0;
        tick();
        snd_irqn = 1'b1;
    endtask

    // counts enabled edges while nmi_n is low, until it rises; -1 if it never rises in budget
    task automatic count_nmi(output int n);
        bit seen;
        seen = 1'b0; n = 0;
        for (int i = 0; i < 400; i++) begin
            if (nmi_n === 1'b0) begin
                seen = 1'b1;
                if (cen === 1'b1) n++;
            end else if (seen) begin
                return;
            end
            tick();
        end
        n = -1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL reset_nmi_n: got %b want 1", nmi_n); end
        checks++; if (snd_ack !== 1'b1) begin errors++; $display("FAIL reset_ack: got %b want 1", snd_ack); end
        checks++; if (dout !== 8'hff) begin errors++; $display("FAIL reset_dout: got %h want ff", dout); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        do_read();
        checks++; if (dout !== 8'hff) begin errors++; $display("FAIL idle_read_dout: got %h want ff", dout); end
        checks++; if (snd_ack !== 1'b1) begin errors++; $display("FAIL idle_read_ack: got %b want 1", snd_ack); end
        end_read();
    endtask

    task automatic test_single_cmd();
        int n;
        do_reset();
        fire_cmd(8'h42);
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL cmd_pending: got %b want 1", pending); end
        checks++; if (snd_ack !== 1'b0) begin errors++; $display("FAIL cmd_ack: got %b want 0", snd_ack); end
        count_nmi(n);
        checks++; if (n !== NMI_LEN) begin errors++; $display("FAIL nmi_len: got %0d want %0d", n, NMI_LEN); end
        do_read();
        checks++; if (dout !== 8'h42) begin errors++; $display("FAIL cmd_read_dout: got %h want 42", dout); end
        checks++; if (snd_ack !== 1'b1) begin errors++; $display("FAIL cmd_read_ack: got %b want 1", snd_ack); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL cmd_read_pending: got %b want 0", pending); end
        end_read();
    endtask

`ifndef JTS16_SNDCMD_FIFO_EN
    task automatic test_overrun();
        int n;
        do_reset();
        fire_cmd(8'h10);
        repeat (5) tick();
        fire_cmd(8'h20);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovr_ovf: got %b want 1", ovf); end
        checks++; if (snd_ack !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %b want 0", snd_ack); end
        count_nmi(n);
        checks++; if (n !== NMI_LEN) begin errors++; $display("FAIL ovr_nmi_restart: got %0d want %0d", n, NMI_LEN); end
        do_read();
        checks++; if (dout !== 8'h20) begin errors++; $display("FAIL ovr_read_dout: got %h want 20", dout); end
        end_read();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", ovf); end
    endtask
`endif

    task automatic test_read_during_nmi();
        bit low_seen;
        do_reset();
        fire_cmd(8'h33);
        repeat (6) tick();
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL rdn_nmi_low: got %b want 0", nmi_n); end
        do_read();
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL rdn_release: got %b want 1", nmi_n); end
        checks++; if (dout !== 8'h33) begin errors++; $display("FAIL rdn_dout: got %h want 33", dout); end
        checks++; if (snd_ack !== 1'b1) begin errors++; $display("FAIL rdn_ack: got %b want 1", snd_ack); end
        end_read();
        low_seen = 1'b0;
        repeat (60) begin
            if (nmi_n !== 1'b1) low_seen = 1'b1;
            tick();
        end
        checks++; if (low_seen !== 1'b0) begin errors++; $display("FAIL rdn_second_nmi: got %b want 0", low_seen); end
    endtask

    task automatic test_fall_and_read();
        int n;
        do_reset();
        fire_cmd(8'h01);
        count_nmi(n);
        read_and_fall(8'h02);
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL far_dout: got %h want 01", dout); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL far_pending: got %b want 1", pending); end
        checks++; if (snd_ack !== 1'b0) begin errors++; $display("FAIL far_ack: got %b want 0", snd_ack); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL far_ovf: got %b want 0", ovf); end
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL far_nmi: got %b want 0", nmi_n); end
        end_read();
        count_nmi(n);
        do_read();
        checks++; if (dout !== 8'h02) begin errors++; $display("FAIL far_second_read: got %h want 02", dout); end
        end_read();
    endtask

    task automatic test_held_low();
        int  n;
        bit  again;
        do_reset();
        snd_latch = 8'h55; snd_irqn = 1'b0;
        tick();
        count_nmi(n);
        do_read();
        checks++; if (dout !== 8'h55) begin errors++; $display("FAIL held_dout: got %h want 55", dout); end
        end_read();
        again = 1'b0;
        repeat (80) begin
            if (nmi_n !== 1'b1 || pending !== 1'b0) again = 1'b1;
            tick();
        end
        checks++; if (again !== 1'b0) begin errors++; $display("FAIL held_retrigger: got %b want 0", again); end
        snd_irqn = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_nmi();
        do_reset();
        fire_cmd(8'h77);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL rst_nmi: got %b want 1", nmi_n); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b want 0", pending); end
        rst = 1'b0;
        tick();
        do_read();
        checks++; if (dout !== 8'hff) begin errors++; $display("FAIL rst_lost: got %h want ff", dout); end
        end_read();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         op;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 3));
            if (op <= 1) begin
                b = 8'($urandom);
                tick();
                fire_cmd(b);
`ifdef JTS16_SNDCMD_FIFO_EN
                if (q.size() == FIFO_DEPTH) exp_ovf = 1'b1;
                else q.push_back(b);
`else
                if (q.size() != 0) begin exp_ovf = 1'b1; q[0] = b; end
                else q.push_back(b);
                checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL rnd_cmd_nmi[%0d]: got %b want 0", k, nmi_n); end
`endif
                checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rnd_cmd_pending[%0d]: got %b want 1", k, pending); end
                checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL rnd_cmd_ovf[%0d]: got %b want %b", k, ovf, exp_ovf); end
            end else if (op == 2) begin
                do_read();
                if (q.size() != 0) exp_dout = q.pop_front();
                checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rnd_rd_dout[%0d]: got %h want %h", k, dout, exp_dout); end
                checks++; if (pending !== (q.size() != 0)) begin errors++; $display("FAIL rnd_rd_pending[%0d]: got %b want %b", k, pending, q.size() != 0); end
                checks++; if (snd_ack !== (q.size() == 0)) begin errors++; $display("FAIL rnd_rd_ack[%0d]: got %b want %b", k, snd_ack, q.size() == 0); end
                checks++; if (nmi_n !== (q.size() == 0)) begin errors++; $display("FAIL rnd_rd_nmi[%0d]: got %b want %b", k, nmi_n, q.size() == 0); end
                end_read();
            end else begin
                repeat ($urandom_range(0, 40)) tick();
            end
        end
    endtask

`ifdef JTS16_SNDCMD_FIFO_EN
    task automatic test_fifo_burst();
        int         n;
        logic [7:0] want;
        logic       want_ack;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            want = 8'hA1 + 8'(k);
            fire_cmd(want);
            tick();
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL fifo_ovf: got %b want 1", ovf); end
        checks++; if (snd_ack !== 1'b0) begin errors++; $display("FAIL fifo_ack_full: got %b want 0", snd_ack); end
        for (int k = 0; k < 4; k++) begin
            count_nmi(n);
            checks++; if (n < 1) begin errors++; $display("FAIL fifo_nmi[%0d]: got %0d ticks want at least 1", k, n); end
            do_read();
            want = 8'hA1 + 8'(k);
            want_ack = (k == 3);
            checks++; if (dout !== want) begin errors++; $display("FAIL fifo_dout[%0d]: got %h want %h", k, dout, want); end
            checks++; if (snd_ack !== want_ack) begin errors++; $display("FAIL fifo_ack[%0d]: got %b want %b", k, snd_ack, want_ack); end
            end_read();
        end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL fifo_drained: got %b want 0", pending); end
    endtask
`endif

    initial begin
        rst = 1'b1; snd_irqn = 1'b1; latch_cs = 1'b0; rd_n = 1'b1; snd_latch = 8'h00;
        tick();
        test_reset();
        test_single_cmd();
`ifndef JTS16_SNDCMD_FIFO_EN
        test_overrun();
`endif
        test_read_during_nmi();
        test_fall_and_read();
        test_held_low();
        test_reset_mid_nmi();
        test_random();
`ifdef JTS16_SNDCMD_FIFO_EN
        test_fifo_burst();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
